// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the uart_tx arbiter slice.
// FSM state encodings and default sizing live here.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_LENGTH  = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } arb_state_e;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: rotate by ptr, priority-encode, un-rotate.
// Purely combinational; lowest index at or above ptr wins.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_REQ,
  parameter int unsigned IW = idx_w(DEF_NUM_REQ)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  enc;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IW'(i);
    end
    // ptr < N and enc < N, so one subtract folds the wrap
    sum = {1'b0, enc} + {1'b0, ptr_i};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o = sum[IW-1:0];
    any_o = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serialiser between NUM_REQ requesters.
// Round-robin grant, word latch, start pulse, done-edge wait, timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned LENGTH  = DEF_LENGTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*LENGTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [LENGTH-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        sent,
  output logic                        timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  arb_state_e          state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       rr_ptr_d;
  logic [TW-1:0]       timer_q;
  logic                done_q;
  logic [LENGTH-1:0]   tx_data_q;
  logic [LENGTH-1:0]   word_d;
  logic [IW-1:0]       grant_q;
  logic [NUM_REQ-1:0]  ready_q;
  logic                start_q;
  logic                busy_q;
  logic                sent_q;
  logic                terr_q;

  logic                pick_any;
  logic [IW-1:0]       pick_idx;

  uart_tx_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    word_d   = req_data[pick_idx*LENGTH +: LENGTH];
    rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= '0;
      ready_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && pick_any) begin
            tx_data_q <= word_d;
            grant_q   <= pick_idx;
            ready_q   <= NUM_REQ'(1) << pick_idx;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end
        S_START: begin
          // sample done here so a level left over from the
          // previous word is not mistaken for completion
          start_q <= 1'b0;
          ready_q <= '0;
          timer_q <= '0;
          done_q  <= tx_done;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          done_q <= tx_done;
          if (tx_done && !done_q) begin
            sent_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == T_LAST) begin
              terr_q  <= 1'b1;
              state_q <= S_ABORT;
            end
          end
        end
        S_DONE: begin
          sent_q   <= 1'b0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= S_IDLE;
        end
        S_ABORT: begin
          terr_q   <= 1'b0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= S_IDLE;
        end
        default: begin
          start_q <= 1'b0;
          ready_q <= '0;
          sent_q  <= 1'b0;
          terr_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = start_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign sent        = sent_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a transmitter stub.
// Stub clears done on load and can hang to force a timeout.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int LEN  = 8;
  localparam int TMO  = 64;
  localparam int XFER = 10;

  logic            clk = 1'b0;
  logic            rstn;
  logic            enable;
  logic [NR-1:0]   req_valid;
  logic [NR*LEN-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [LEN-1:0]  tx_data;
  logic            tx_start;
  logic            tx_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            sent;
  logic            timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .LENGTH  (LEN),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .sent        (sent),
    .timeout_err (timeout_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // transmitter stub
  bit         hang = 1'b0;
  int         hold = 0;
  logic [7:0] scnt;
  bit         sact;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_done <= 1'b0;
      sact    <= 1'b0;
      scnt    <= 8'd0;
    end else if (tx_start) begin
      sact <= 1'b1;
      scnt <= 8'd0;
    end else if (sact) begin
      if (scnt != 8'hFF) scnt <= scnt + 8'd1;
      if (scnt == hold[7:0]) tx_done <= 1'b0;
      if (scnt == XFER[7:0] && !hang) begin
        tx_done <= 1'b1;
        sact    <= 1'b0;
      end
    end
  end

  // requester queues
  typedef logic [7:0] wq_t [$];
  wq_t wq [NR];

  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (rstn && req_ready[i] && wq[i].size() > 0)
          void'(wq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (wq[i].size() > 0);
        req_data[i*LEN +: LEN] =
          (wq[i].size() > 0) ? wq[i][0] : 8'h00;
      end
    end
  end

  // scoreboard
  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   inflight = 1'b0;
  bit   stable   = 1'b1;
  int   t_start  = 0;
  int   nstart   = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        inflight = 1'b0;
      end else begin
        if (inflight && busy && tx_data !== cur.data)
          stable = 1'b0;
        if (req_ready != '0 && !tx_start)
          chk("ready_without_start", req_ready, 0);
        if (tx_start) begin
          nstart++;
          chk("start_gap", inflight, 0);
          chk("start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("grant_id", grant_id, cur.gid);
            chk("req_ready", req_ready, 4'b1 << cur.gid);
            chk("tx_data", tx_data, cur.data);
            inflight = 1'b1;
            stable   = 1'b1;
            t_start  = cyc;
          end
        end
        if (sent || timeout_err) begin
          chk("end_inflight", inflight, 1);
          chk("end_both", sent & timeout_err, 0);
          chk("end_kind", timeout_err, cur.to);
          chk("end_delay", cyc - t_start,
              cur.to ? TMO + 1 : XFER + 3);
          chk("tx_data_stable", stable, 1);
          inflight = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !inflight && !busy) return;
    end
    chk("drain_timeout",
        {exp_q.size() != 0, inflight, busy}, 0);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (!inflight && !busy) return;
    end
    chk("idle_timeout", {inflight, busy}, 0);
  endtask

  task automatic wait_inflight(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (inflight) return;
    end
    chk("start_timeout", inflight, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_data"},  tx_data, 0);
    chk({tag, "_gid"},   grant_id, 0);
    chk({tag, "_sent"},  sent, 0);
    chk({tag, "_terr"},  timeout_err, 0);
  endtask

  task automatic push(input logic [1:0] g,
                      input logic [7:0] d,
                      input logic t);
    exp_t e;
    e.gid  = g;
    e.data = d;
    e.to   = t;
    exp_q.push_back(e);
  endtask

  int n0;

  initial begin
    rstn   = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;

    // single requester 1
    push(2'd1, 8'hA5, 1'b0);
    wq[1].push_back(8'hA5);
    wait_drain(200);

    // reset in the middle of WAIT
    push(2'd3, 8'h77, 1'b0);
    wq[3].push_back(8'h77);
    wait_inflight(50);
    repeat (3) @(negedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    for (int i = 0; i < NR; i++) wq[i].delete();
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // round robin from ptr 0, stale done held longer
    hold = 4;
    push(2'd0, 8'h11, 1'b0);
    push(2'd1, 8'h22, 1'b0);
    push(2'd2, 8'h33, 1'b0);
    push(2'd3, 8'h44, 1'b0);
    push(2'd0, 8'h55, 1'b0);
    wq[0].push_back(8'h11);
    wq[0].push_back(8'h55);
    wq[1].push_back(8'h22);
    wq[2].push_back(8'h33);
    wq[3].push_back(8'h44);
    wait_drain(400);
    hold = 0;

    // hung transmitter: ptr=1, only req2
    hang = 1'b1;
    push(2'd2, 8'hC3, 1'b1);
    wq[2].push_back(8'hC3);
    wait_drain(200);
    hang = 1'b0;
    push(2'd3, 8'hE3, 1'b0);
    push(2'd0, 8'hD0, 1'b0);
    wq[0].push_back(8'hD0);
    wq[3].push_back(8'hE3);
    wait_drain(300);

    // enable drop during WAIT
    push(2'd1, 8'hF1, 1'b0);
    wq[1].push_back(8'hF1);
    wait_inflight(50);
    repeat (2) @(negedge clk);
    #1;
    enable = 1'b0;
    wq[0].push_back(8'hA0);
    wq[1].push_back(8'hB1);
    wq[2].push_back(8'hC2);
    wq[3].push_back(8'hD3);
    wait_idle(100);
    n0 = nstart;
    repeat (30) @(negedge clk);
    #1;
    chk("no_start_disabled", nstart - n0, 0);
    chk("idle_disabled", busy, 0);
    push(2'd2, 8'hC2, 1'b0);
    push(2'd3, 8'hD3, 1'b0);
    push(2'd0, 8'hA0, 1'b0);
    push(2'd1, 8'hB1, 1'b0);
    enable = 1'b1;
    wait_drain(400);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
